uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 2604, clock cycles per UART bit period; minimum 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame; range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; range 1..2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, received-word buffer entries; power of two, minimum 2.
REQ-006 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port RST_N, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port UART_RX, input, 1, asynchronous serial line; idle high.
REQ-009 SHALL have port DATA, output, DATA_BITS, FIFO head word.
REQ-010 SHALL have port VALID, output, 1, FIFO non-empty.
REQ-011 SHALL have port READY, input, 1, consumer accepts DATA when VALID and READY are both high.
REQ-012 SHALL have port FRAME_ERR, output, 1, one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port PARITY_ERR, output, 1, one-cycle pulse on a parity mismatch.
REQ-014 SHALL have port OVERRUN, output, 1, one-cycle pulse when a good word is dropped because the FIFO is full.
REQ-015 SHALL have port BUSY, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL pass UART_RX through a 2-flop synchronizer; all line logic SHALL use the synchronized value.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-018 IDLE SHALL move to START on a synchronized high-to-low transition and clear the bit-period counter.
REQ-019 START SHALL sample the line at count CLKS_PER_BIT/2: low goes to DATA, high (glitch) returns to IDLE with nothing reported.
REQ-020 DATA SHALL sample each bit CLKS_PER_BIT cycles after the previous sample and shift it in LSB first, DATA_BITS times.
REQ-021 After DATA the FSM SHALL go to PARITY if PARITY is not 0, otherwise to STOP.
REQ-022 PARITY SHALL sample one bit and compare it with the even or odd parity of the payload.
REQ-023 STOP SHALL sample STOP_BITS bits; any low sample makes the frame fail.
REQ-024 On a good frame the FSM SHALL return to IDLE in the cycle after the last mid-stop sample, so back-to-back frames are accepted.
REQ-025 Precedence at frame end SHALL be: framing error, then parity error, then overrun, then push.
REQ-026 A framing error SHALL discard the word, pulse FRAME_ERR, and move to BREAK.
REQ-027 BREAK SHALL wait for the synchronized line to be high, then enter IDLE.
REQ-028 A parity error SHALL discard the word, pulse PARITY_ERR, and return to IDLE.
REQ-029 A good word SHALL be pushed into the FIFO in the cycle after the final stop sample.
REQ-030 VALID and DATA SHALL reflect the pushed word one cycle after the push (registered FIFO state).
REQ-031 Pop SHALL occur on VALID and READY; push and pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-032 When the FIFO is full and there is no pop, a good word SHALL be dropped and OVERRUN pulsed; stored contents SHALL be unchanged.
REQ-033 FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits with wrap-around; full when the MSBs differ and the rest are equal.
REQ-034 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide.

Reset
REQ-035 RST_N low SHALL immediately force: FSM to IDLE, counters, shift register and FIFO pointers to 0, synchronizer flops to 1.
REQ-036 During reset SHALL hold VALID, BUSY, FRAME_ERR, PARITY_ERR and OVERRUN at 0, and DATA at 0.
REQ-037 Reset mid-frame SHALL abandon the frame; the remainder of that frame SHALL NOT produce a word or an error pulse unless a new falling edge validates as a start bit.

Structure
REQ-038 A shared package SHALL hold the FSM state enum and the parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-039 The FIFO SHALL be a sub-module named rx_fifo, parametrised by width and depth, with push/pop/full/empty ports.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-040 Frame 0x53, PARITY 0, READY=1 -> VALID high for 1 cycle with DATA=0x53; no error pulses.
REQ-041 Bytes 53 D3 53 F7 00 53 53 57 sent back-to-back with READY=0 and FIFO_DEPTH=4 -> FIFO holds 53 D3 53 F7; 4 OVERRUN pulses; raising READY then drains exactly those 4 words in order.
REQ-042 Line low for 4 cycles, then high -> no START-to-DATA transition; BUSY returns to 0; no outputs or pulses.
REQ-043 Frame 0x53 with stop bit 0, line then held low for 40 cycles -> FRAME_ERR pulses once, VALID stays 0, BUSY stays 1 until the line goes high.
REQ-044 PARITY=1, payload 0x53 sent with parity bit 1 -> PARITY_ERR pulses once, no push; the same frame with parity bit 0 -> DATA=0x53.
REQ-045 RST_N pulsed low during bit 3 of a frame -> outputs are 0 immediately; no word or error results from the rest of that frame.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// parity-mode constants and the parity helper used at the parity sample.
package uart_receiver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   // Expected parity bit for a payload; zero-extension does not change the XOR.
   function automatic logic parity_bit(input logic [8:0] word, input int unsigned mode);
      return (mode == PAR_ODD) ? ~(^word) : (^word);
   endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// Received-word buffer: power-of-two depth, extra-MSB pointers, simultaneous
// push and pop allowed even when full. Head word reads as zero while empty.
module rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 2-flop line synchronizer, mid-bit sampling FSM
// with optional parity and 1-2 stop bits, results buffered in rx_fifo.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 2604,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 UART_RX,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 VALID,
   input  logic                 READY,
   output logic                 FRAME_ERR,
   output logic                 PARITY_ERR,
   output logic                 OVERRUN,
   output logic                 BUSY
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = 4;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t            state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic                 rx_prev_q, rx_prev_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic                 stop_bad_q, stop_bad_d;
   logic                 push_q, push_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 rx, tick, pop, fifo_full, fifo_empty;

   assign rx = sync_q[1];

   always_comb begin
      sync_d     = {sync_q[0], UART_RX};
      rx_prev_d  = rx;
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_bad_d  = par_bad_q;
      stop_bad_d = stop_bad_q;
      push_d     = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      tick       = (cnt_q == CNT_LAST);
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d      = '0;
               bit_d      = '0;
               par_bad_d  = 1'b0;
               stop_bad_d = 1'b0;
               state_d    = rx ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               cnt_d   = '0;
               shift_d = {rx, shift_q[DATA_BITS-1:1]};
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               cnt_d     = '0;
               par_bad_d = (rx != parity_bit(9'(shift_q), PARITY));
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               cnt_d = '0;
               // Outcome is registered so pulses and the push land one cycle after the last sample.
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  if (stop_bad_q || !rx) begin
                     ferr_d  = 1'b1;
                     state_d = ST_BREAK;
                  end else if (par_bad_q) begin
                     perr_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     push_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  stop_bad_d = stop_bad_q || !rx;
                  bit_d      = bit_q + 1'b1;
               end
            end
         end
         ST_BREAK: begin
            cnt_d = '0;
            if (rx) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         sync_q     <= '1;
         rx_prev_q  <= 1'b1;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_bad_q  <= 1'b0;
         stop_bad_q <= 1'b0;
         push_q     <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         rx_prev_q  <= rx_prev_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_bad_q  <= par_bad_d;
         stop_bad_q <= stop_bad_d;
         push_q     <= push_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
      end
   end

   rx_fifo #(
      .WIDTH(DATA_BITS),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (CLK),
      .rst_n(RST_N),
      .push (push_q),
      .wdata(shift_q),
      .pop  (pop),
      .rdata(DATA),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign VALID      = !fifo_empty;
   assign pop        = VALID && READY;
   assign BUSY       = (state_q != ST_IDLE);
   assign FRAME_ERR  = ferr_q;
   assign PARITY_ERR = perr_q;
   assign OVERRUN    = push_q && fifo_full && !pop;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver: two instances (no parity / 1 stop, even
// parity / 2 stop) driven bit-by-bit and checked against a frame-level model.
module tb_uart_receiver;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx0, rx1, rdy0, rdy1;
   logic [7:0] data0, data1;
   logic       valid0, ferr0, perr0, ovr0, busy0;
   logic       valid1, ferr1, perr1, ovr1, busy1;

   always #5 clk = ~clk;

   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
      .CLK(clk), .RST_N(rst_n), .UART_RX(rx0), .DATA(data0), .VALID(valid0), .READY(rdy0),
      .FRAME_ERR(ferr0), .PARITY_ERR(perr0), .OVERRUN(ovr0), .BUSY(busy0));

   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_par (
      .CLK(clk), .RST_N(rst_n), .UART_RX(rx1), .DATA(data1), .VALID(valid1), .READY(rdy1),
      .FRAME_ERR(ferr1), .PARITY_ERR(perr1), .OVERRUN(ovr1), .BUSY(busy1));

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Observed behaviour
   logic [7:0]  got0[$], got1[$];
   int unsigned ferr_n0 = 0, perr_n0 = 0, ovr_n0 = 0, vcyc0 = 0;
   int unsigned ferr_n1 = 0, perr_n1 = 0, ovr_n1 = 0;

   // Reference model state
   logic [7:0]  exp0[$], exp1[$];
   int unsigned eferr0 = 0, eperr0 = 0, eovr0 = 0;
   int unsigned eferr1 = 0, eperr1 = 0, eovr1 = 0;
   bit          hold0 = 1'b0;
   int unsigned held0 = 0;
   bit          rnd_rdy = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid0 && rdy0) got0.push_back(data0);
         if (valid1 && rdy1) got1.push_back(data1);
         vcyc0   += int'(valid0);
         ferr_n0 += int'(ferr0);
         perr_n0 += int'(perr0);
         ovr_n0  += int'(ovr0);
         ferr_n1 += int'(ferr1);
         perr_n1 += int'(perr1);
         ovr_n1  += int'(ovr1);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_line(input int unsigned inst, input logic v);
      if (inst == 0) rx0 = v;
      else rx1 = v;
   endtask

   task automatic idle(input int unsigned cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Frame-level model: stop error beats parity error beats overrun beats store.
   task automatic model_frame(input int unsigned inst, input logic [7:0] d, input logic par_ok, input logic stop_ok);
      if (inst == 0) begin
         if (!stop_ok) eferr0++;
         else if (hold0 && held0 == 4) eovr0++;
         else begin
            exp0.push_back(d);
            if (hold0) held0++;
         end
      end else begin
         if (!stop_ok) eferr1++;
         else if (!par_ok) eperr1++;
         else exp1.push_back(d);
      end
   endtask

   // rst_at >= 0 pulses reset in the middle of that payload bit and skips the model.
   task automatic send_frame(input int unsigned inst, input logic [7:0] d, input logic par_flip,
                             input logic stop_low, input int rst_at);
      logic [11:0] b;
      int unsigned n;
      b = '0;
      b[0] = 1'b0;
      for (int unsigned i = 0; i < 8; i++) b[i+1] = d[i];
      n = 9;
      if (inst == 1) begin
         b[n] = (^d) ^ par_flip;
         n++;
      end
      for (int unsigned s = 0; s < ((inst == 1) ? 2 : 1); s++) begin
         b[n] = ~stop_low;
         n++;
      end
      for (int unsigned k = 0; k < n; k++) begin
         set_line(inst, b[k]);
         for (int unsigned c = 0; c < CPB; c++) begin
            if (rst_at >= 0 && int'(k) == rst_at + 1 && c == 5) begin
               check_eq("pre_rst_valid", valid0, 1);
               check_eq("pre_rst_busy", busy0, 1);
               rst_n = 1'b0;
               #2;
               check_eq("rst_mid_valid", valid0, 0);
               check_eq("rst_mid_busy", busy0, 0);
               check_eq("rst_mid_data", data0, 0);
            end
            if (rst_at >= 0 && int'(k) == rst_at + 1 && c == 8) rst_n = 1'b1;
            @(posedge clk);
            #1;
            if (rnd_rdy) begin
               rdy0 = 1'($urandom_range(0, 1));
               rdy1 = 1'($urandom_range(0, 1));
            end
         end
      end
      if (rst_at < 0) model_frame(inst, d, ~par_flip, ~stop_low);
   endtask

   task automatic check_counts(input string tag);
      check_eq({tag, "_ferr0"}, ferr_n0, eferr0);
      check_eq({tag, "_perr0"}, perr_n0, eperr0);
      check_eq({tag, "_ovr0"}, ovr_n0, eovr0);
      check_eq({tag, "_ferr1"}, ferr_n1, eferr1);
      check_eq({tag, "_perr1"}, perr_n1, eperr1);
      check_eq({tag, "_ovr1"}, ovr_n1, eovr1);
   endtask

   task automatic check_words(input string tag, input int unsigned inst);
      if (inst == 0) begin
         check_eq({tag, "_count0"}, got0.size(), exp0.size());
         for (int i = 0; i < exp0.size() && i < got0.size(); i++) check_eq({tag, "_word0"}, got0[i], exp0[i]);
         got0.delete();
         exp0.delete();
      end else begin
         check_eq({tag, "_count1"}, got1.size(), exp1.size());
         for (int i = 0; i < exp1.size() && i < got1.size(); i++) check_eq({tag, "_word1"}, got1[i], exp1[i]);
         got1.delete();
         exp1.delete();
      end
   endtask

   initial begin
      logic [7:0]  burst [8];
      int unsigned v_before;
      logic        bad;
      burst = '{8'h53, 8'hD3, 8'h53, 8'hF7, 8'h00, 8'h53, 8'h53, 8'h57};

      rst_n = 1'b0;
      rx0 = 1'b1; rx1 = 1'b1;
      rdy0 = 1'b0; rdy1 = 1'b0;
      idle(3);
      check_eq("rst_valid", valid0, 0);
      check_eq("rst_busy", busy0, 0);
      check_eq("rst_ferr", ferr0, 0);
      check_eq("rst_perr", perr0, 0);
      check_eq("rst_ovr", ovr0, 0);
      check_eq("rst_data", data0, 0);
      check_eq("rst_valid1", valid1, 0);
      rst_n = 1'b1;
      idle(4);

      // Single good frame, consumer always ready
      rdy0 = 1'b1; rdy1 = 1'b1;
      v_before = vcyc0;
      send_frame(0, 8'h53, 1'b0, 1'b0, -1);
      idle(2 * CPB);
      check_eq("single_valid_cycles", vcyc0 - v_before, 1);
      check_words("single", 0);
      check_counts("single");

      // Random traffic with random READY on both instances
      rnd_rdy = 1'b1;
      for (int unsigned i = 0; i < 24; i++) begin
         bad = ($urandom_range(0, 5) == 0);
         send_frame(i % 2, 8'($urandom), 1'((i % 2 == 1) && ($urandom_range(0, 3) == 0)), bad, -1);
         set_line(i % 2, 1'b1);
         idle(bad ? 2 * CPB : $urandom_range(0, CPB));
      end
      rnd_rdy = 1'b0;
      rdy0 = 1'b1; rdy1 = 1'b1;
      idle(2 * CPB);
      check_words("random", 0);
      check_words("random", 1);
      check_counts("random");

      // Back-to-back burst into a stalled FIFO
      rdy0 = 1'b0;
      hold0 = 1'b1; held0 = 0;
      for (int unsigned i = 0; i < 8; i++) send_frame(0, burst[i], 1'b0, 1'b0, -1);
      idle(CPB);
      check_counts("burst");
      check_eq("burst_valid", valid0, 1);
      check_eq("burst_head", data0, exp0[0]);
      check_eq("burst_none_popped", got0.size(), 0);
      rdy0 = 1'b1;
      hold0 = 1'b0;
      idle(12);
      check_words("burst_drain", 0);
      check_eq("burst_drained_valid", valid0, 0);

      // Short low glitch must not start a frame
      v_before = vcyc0;
      rx0 = 1'b0;
      idle(4);
      rx0 = 1'b1;
      idle(2);
      check_eq("glitch_busy_hi", busy0, 1);
      idle(20);
      check_eq("glitch_busy_lo", busy0, 0);
      check_eq("glitch_no_valid", vcyc0 - v_before, 0);
      check_words("glitch", 0);
      check_counts("glitch");

      // Bad stop bit, line then held low
      send_frame(0, 8'h53, 1'b0, 1'b1, -1);
      idle(40);
      check_counts("break");
      check_eq("break_busy", busy0, 1);
      check_eq("break_valid", valid0, 0);
      rx0 = 1'b1;
      idle(5);
      check_eq("break_exit_busy", busy0, 0);
      check_words("break", 0);

      // Even parity: wrong then right parity bit for 0x53
      send_frame(1, 8'h53, 1'b1, 1'b0, -1);
      idle(CPB);
      send_frame(1, 8'h53, 1'b0, 1'b0, -1);
      idle(CPB);
      check_counts("parity");
      check_words("parity", 1);

      // Reset during payload bit 3 with a word already buffered
      rdy0 = 1'b0;
      hold0 = 1'b1; held0 = 0;
      send_frame(0, 8'hA5, 1'b0, 1'b0, -1);
      idle(CPB);
      send_frame(0, 8'hF8, 1'b0, 1'b0, 3);
      exp0.delete();
      held0 = 0;
      hold0 = 1'b0;
      rdy0 = 1'b1;
      idle(2 * CPB);
      check_eq("post_rst_valid", valid0, 0);
      check_eq("post_rst_busy", busy0, 0);
      check_words("post_rst", 0);
      check_counts("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
